// File: rtl/mult_pkg.sv
// Shared constants for the serial shift-and-add multiplier slice:
// default operand width and the controller state encoding.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/shift_add_mult_if.sv
// Handshake and operand bundle between a caller (master) and the multiplier core (slave).
interface shift_add_mult_if import mult_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic                 START;
    logic [WIDTH-1:0]     MCAND;
    logic                 MBIT;
    logic                 SH_EN;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   PRODUCT;

    modport master (
        output START, MCAND, MBIT,
        input  SH_EN, BUSY, DONE, PRODUCT
    );

    modport slave (
        input  START, MCAND, MBIT,
        output SH_EN, BUSY, DONE, PRODUCT
    );

endinterface

// File: rtl/serial_add_step.sv
// One shift-and-add iteration: add the multiplicand to the accumulator's upper half
// when the current multiplier bit is set, keeping the carry.
module serial_add_step import mult_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc_hi_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             mbit_i,
    output logic [WIDTH:0]   sum_o
);

    logic [WIDTH-1:0] addend;

    assign addend = {WIDTH{mbit_i}} & mcand_i;
    assign sum_o  = acc_hi_i + {1'b0, addend};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier consuming the multiplier LSB-first from an
// upstream shift register, which it advances via SH_EN.
module shift_add_mult import mult_pkg::*; #(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic             CLK,
    input logic             RST,
    shift_add_mult_if.slave bus
);

    state_t               state_q, state_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     acc_shift;

    serial_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi_i (acc_q[2*WIDTH:WIDTH]),
        .mcand_i  (mcand_q),
        .mbit_i   (bus.MBIT),
        .sum_o    (sum)
    );

    // Partial product lands in the upper half; the whole accumulator then shifts right.
    assign acc_shift = {sum, acc_q[WIDTH-1:0]} >> 1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    mcand_d = bus.MCAND;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = ST_DONE;
                    product_d = acc_shift[2*WIDTH-1:0];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    assign bus.SH_EN   = (state_q == ST_RUN);
    assign bus.BUSY    = (state_q != ST_IDLE);
    assign bus.DONE    = (state_q == ST_DONE);
    assign bus.PRODUCT = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult with a behavioural upstream shift register.
module tb_shift_add_mult;
    import mult_pkg::*;

    localparam int unsigned W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    shift_add_mult_if #(.WIDTH(W)) bus ();

    shift_add_mult #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Upstream multiplier register: parallel load, shifts right on SH_EN.
    logic [W-1:0] sr;
    logic [W-1:0] load_val;
    logic         load_req;
    always @(posedge CLK) begin
        if (load_req)       sr <= load_val;
        else if (bus.SH_EN) sr <= sr >> 1;
    end
    assign bus.MBIT = sr[0];

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc[$];
    logic [2*W-1:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor samples at negedge; stimulus is driven just after posedge.
    logic           in_flight = 1'b0;
    logic           hold_valid = 1'b0;
    logic           prev_done = 1'b0;
    int unsigned    lat = 0;
    int unsigned    sh = 0;
    logic [2*W-1:0] held = '0;
    logic [2*W-1:0] exp_p;

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            in_flight  = 1'b0;
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) check_eq("product_hold", 32'(bus.PRODUCT), 32'(held));
            if (in_flight) begin
                lat++;
                if (bus.SH_EN) sh++;
            end
            if (bus.DONE) begin
                if (prev_done) check_eq("done_pulse", 32'(prev_done), 32'd0);
                if (sb.size() == 0 || !in_flight) begin
                    check_eq("done_without_issue", 32'(bus.DONE), 32'd0);
                end else begin
                    exp_p = sb.pop_front();
                    check_eq("product", 32'(bus.PRODUCT), 32'(exp_p));
                    check_eq("latency", lat, W + 1);
                    check_eq("sh_en_cycles", sh, W);
                    check_eq("busy_in_done", 32'(bus.BUSY), 32'd1);
                    check_eq("sh_en_in_done", 32'(bus.SH_EN), 32'd0);
                end
                held       = bus.PRODUCT;
                hold_valid = 1'b1;
                in_flight  = 1'b0;
                done_cyc.push_back(cyc);
            end
            if (!bus.BUSY && bus.START) begin
                in_flight  = 1'b1;
                lat        = 0;
                sh         = 0;
                hold_valid = 1'b0;
            end
        end
        prev_done = bus.DONE;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.DONE) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("done_timeout", 32'(bus.DONE), 32'd1);
    endtask

    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        tick();
        bus.START = 1'b1;
        bus.MCAND = a;
        load_val  = b;
        load_req  = 1'b1;
        sb.push_back((2*W)'(a) * (2*W)'(b));
        tick();
        bus.START = 1'b0;
        load_req  = 1'b0;
        bus.MCAND = W'($urandom_range(15));
        wait_done();
    endtask

    initial begin
        bus.START = 1'b0;
        bus.MCAND = '0;
        load_val  = '0;
        load_req  = 1'b0;

        repeat (2) tick();
        check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("rst_done", 32'(bus.DONE), 32'd0);
        check_eq("rst_sh_en", 32'(bus.SH_EN), 32'd0);
        check_eq("rst_product", 32'(bus.PRODUCT), 32'd0);
        RST = 1'b0;

        do_mult(4'd13, 4'd11);
        do_mult(4'd0, 4'd15);
        do_mult(4'd15, 4'd0);
        do_mult(4'd15, 4'd15);

        // START held high across two operations.
        tick();
        bus.START = 1'b1;
        bus.MCAND = 4'd6;
        load_val  = 4'd7;
        load_req  = 1'b1;
        sb.push_back(8'd42);
        tick();
        bus.MCAND = 4'd5;
        load_req  = 1'b0;
        wait_done();
        load_val = 4'd3;
        load_req = 1'b1;
        sb.push_back(8'd15);
        tick();
        tick();
        bus.START = 1'b0;
        load_req  = 1'b0;
        wait_done();
        if (done_cyc.size() >= 2)
            check_eq("done_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2],
                     32'd6);
        else
            check_eq("done_count", done_cyc.size(), 32'd2);

        // Abort 9*9 in its second RUN cycle.
        tick();
        bus.START = 1'b1;
        bus.MCAND = 4'd9;
        load_val  = 4'd9;
        load_req  = 1'b1;
        tick();
        bus.START = 1'b0;
        load_req  = 1'b0;
        tick();
        check_eq("abort_in_run", 32'(bus.SH_EN), 32'd1);
        RST = 1'b1;
        tick();
        check_eq("abort_busy", 32'(bus.BUSY), 32'd0);
        check_eq("abort_sh_en", 32'(bus.SH_EN), 32'd0);
        check_eq("abort_done", 32'(bus.DONE), 32'd0);
        check_eq("abort_product", 32'(bus.PRODUCT), 32'd0);
        RST = 1'b0;
        repeat (W + 2) tick();
        check_eq("abort_no_done", 32'(bus.DONE), 32'd0);
        do_mult(4'd3, 4'd4);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_mult(W'(a), W'(b));

        repeat (3) tick();
        check_eq("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
